bp_requester: RTL
=================

BP_REQUESTER -- requirements
Module: bp_requester

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: lk_valid input 1, lk_pc input 64, lk_ready output 1: fetch lookup request; accepted when valid&&ready.
REQ-004 SHALL have: pred_valid output 1, pred_taken output 1, pred_target output 64, pred_timeout output 1: one-cycle lookup result pulse.
REQ-005 SHALL have: upd_valid input 1, upd_pc input 64, upd_target input 64, upd_taken input 1, upd_ready output 1: resolved-branch update from execute.
REQ-006 SHALL have: bp_req output 1, bp_mode output 1 (0=read, 1=write), bp_pc output 64, bp_target output 64, bp_taken output 1: command to predictor.
REQ-007 SHALL have: bp_target_in input 64, bp_taken_in input 1, bp_respcyc input 1: predictor response.
REQ-008 SHALL have parameters: UPD_DEPTH default 4 (update FIFO entries, power of 2); TIMEOUT default 8 (cycles to wait for bp_respcyc).

Function
REQ-009 SHALL implement FSM states IDLE, LOOKUP, UPDATE, DRAIN.
REQ-010 SHALL buffer accepted updates in a UPD_DEPTH FIFO of {pc, target, taken}; upd_ready = !full.
REQ-011 In IDLE, lk_ready SHALL be 1; lk_ready SHALL be 0 in every other state.
REQ-012 In IDLE, arbitration SHALL be: FIFO full -> UPDATE; else lk_valid -> LOOKUP (pc captured); else FIFO non-empty -> UPDATE; else stay IDLE.
REQ-013 A lookup accepted while FIFO is full SHALL NOT occur (lk_ready forced 0 when FIFO full).
REQ-014 In LOOKUP and UPDATE, bp_req SHALL be 1 and bp_pc/bp_target/bp_taken/bp_mode SHALL hold constant until exit.
REQ-015 UPDATE SHALL drive the FIFO head with bp_mode=1; head popped on the cycle bp_respcyc=1, then -> DRAIN.
REQ-016 LOOKUP SHALL drive captured pc with bp_mode=0, bp_target=0, bp_taken=0; on bp_respcyc=1, bp_target_in/bp_taken_in registered, -> DRAIN.
REQ-017 pred_valid SHALL pulse exactly one cycle, the cycle after bp_respcyc=1 in LOOKUP, with registered pred_taken/pred_target.
REQ-018 DRAIN SHALL deassert bp_req and wait until bp_respcyc=0, then -> IDLE (predictor returns to idle before next command).
REQ-019 A timeout counter SHALL clear on entry to LOOKUP/UPDATE and count each cycle without bp_respcyc; at TIMEOUT cycles -> DRAIN.
REQ-020 On LOOKUP timeout: pred_valid=1, pred_taken=0, pred_target=0, pred_timeout=1 for one cycle.
REQ-021 On UPDATE timeout: head SHALL NOT be popped (retried next arbitration); no pred_* pulse.
REQ-022 Simultaneous FIFO push (upd_valid&&upd_ready) and pop SHALL keep count unchanged; push when full SHALL be impossible.
REQ-023 FIFO pointers SHALL wrap modulo UPD_DEPTH; count width clog2(UPD_DEPTH)+1.
REQ-024 Minimum lookup latency: lk accept cycle N, bp_req from N+1, respcyc at N+2 -> pred_valid at N+3.

Reset
REQ-025 Reset SHALL force state IDLE, FIFO empty, timeout counter 0.
REQ-026 During and after reset: bp_req=0, bp_mode=0, bp_pc=0, bp_target=0, bp_taken=0, pred_valid=0, pred_taken=0, pred_target=0, pred_timeout=0, upd_ready=1, lk_ready=1.
REQ-027 Reset mid-LOOKUP/UPDATE SHALL abandon the transaction with no pred_valid pulse and discard FIFO contents.

Structure
REQ-028 bp_pkg SHALL hold the state enum, BP_MODE_READ/BP_MODE_WRITE constants, and the update-entry struct.
REQ-029 The update FIFO SHALL be a sub-module bp_upd_fifo; FSM, timeout and output registers stay in bp_requester.

Verification
REQ-030 Lookup pc=0x1000, responder replies 1 cycle later target=0x2000 taken=1 -> pred_valid one cycle, pred_taken=1, pred_target=0x2000.
REQ-031 Push 4 updates with no lookups -> upd_ready=0 after 4th; 4 write commands issued in order, bp_mode=1, pcs match.
REQ-032 FIFO full and lk_valid=1 in IDLE -> UPDATE chosen, lk_ready=0 until a slot frees.
REQ-033 Responder silent on lookup -> after 8 cycles pred_valid=1, pred_taken=0, pred_timeout=1; bp_req drops.
REQ-034 Responder silent on update -> entry not popped, same pc reissued on next UPDATE.
REQ-035 Assert reset during LOOKUP with 2 FIFO entries -> all outputs at reset values, FIFO empty, no pred_valid.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states, predictor command modes and update-entry layout.
package bp_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, DRAIN} state_t;
  localparam logic BP_MODE_READ  = 1'b0;
  localparam logic BP_MODE_WRITE = 1'b1;
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
    logic        taken;
  } upd_entry_t;
endpackage

// File: rtl/bp_requester_if.sv
// bp_requester_if: lookup, result, update and predictor command/response bundle.
interface bp_requester_if;
  logic        lk_valid, lk_ready;
  logic [63:0] lk_pc;
  logic        pred_valid, pred_taken, pred_timeout;
  logic [63:0] pred_target;
  logic        upd_valid, upd_taken, upd_ready;
  logic [63:0] upd_pc, upd_target;
  logic        bp_req, bp_mode, bp_taken;
  logic [63:0] bp_pc, bp_target;
  logic [63:0] bp_target_in;
  logic        bp_taken_in, bp_respcyc;
  modport master (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken,
           bp_target_in, bp_taken_in, bp_respcyc,
    output lk_ready, pred_valid, pred_taken, pred_target, pred_timeout, upd_ready,
           bp_req, bp_mode, bp_pc, bp_target, bp_taken
  );
  modport slave (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken,
           bp_target_in, bp_taken_in, bp_respcyc,
    input  lk_ready, pred_valid, pred_taken, pred_target, pred_timeout, upd_ready,
           bp_req, bp_mode, bp_pc, bp_target, bp_taken
  );
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: power-of-two FIFO of resolved-branch updates awaiting a write slot.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  upd_entry_t din,
  output upd_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  upd_entry_t    mem_q [DEPTH];
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/bp_requester.sv
// bp_requester: arbitrates fetch lookups and buffered updates onto a single
// branch-predictor command port, with response timeout and one-cycle result pulse.
module bp_requester
  import bp_pkg::*;
#(
  parameter int UPD_DEPTH = 4,
  parameter int TIMEOUT   = 8
) (
  input logic clk,
  input logic reset,
  bp_requester_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t        state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [63:0]   pc_q, pc_d, pred_target_q, pred_target_d;
  logic          pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic          pred_timeout_q, pred_timeout_d;
  logic          full, empty, pop, expired;
  upd_entry_t    head, din;
  assign din     = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken};
  assign expired = to_q == TW'(TIMEOUT - 1);
  bp_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.upd_valid),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    state_d        = state_q;
    to_d           = to_q;
    pc_d           = pc_q;
    pred_valid_d   = 1'b0;
    pred_taken_d   = 1'b0;
    pred_target_d  = '0;
    pred_timeout_d = 1'b0;
    pop            = 1'b0;
    case (state_q)
      IDLE: begin
        to_d    = '0;
        state_d = full ? UPDATE : bus.lk_valid ? LOOKUP : !empty ? UPDATE : IDLE;
        pc_d    = (!full && bus.lk_valid) ? bus.lk_pc : pc_q;
      end
      LOOKUP: begin
        state_d        = (bus.bp_respcyc || expired) ? DRAIN : LOOKUP;
        to_d           = to_q + TW'(1);
        pred_valid_d   = bus.bp_respcyc || expired;
        pred_taken_d   = bus.bp_respcyc && bus.bp_taken_in;
        pred_target_d  = bus.bp_respcyc ? bus.bp_target_in : '0;
        pred_timeout_d = !bus.bp_respcyc && expired;
      end
      UPDATE: begin
        // a timed-out write leaves the head in place so arbitration retries it
        state_d = (bus.bp_respcyc || expired) ? DRAIN : UPDATE;
        to_d    = to_q + TW'(1);
        pop     = bus.bp_respcyc;
      end
      DRAIN:   state_d = bus.bp_respcyc ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      to_q           <= '0;
      pc_q           <= '0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= '0;
      pred_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_q           <= to_d;
      pc_q           <= pc_d;
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pred_target_q  <= pred_target_d;
      pred_timeout_q <= pred_timeout_d;
    end
  end
  assign bus.lk_ready     = state_q == IDLE && !full;
  assign bus.upd_ready    = !full;
  assign bus.bp_req       = state_q == LOOKUP || state_q == UPDATE;
  assign bus.bp_mode      = state_q == UPDATE ? BP_MODE_WRITE : BP_MODE_READ;
  assign bus.bp_pc        = state_q == LOOKUP ? pc_q : state_q == UPDATE ? head.pc : '0;
  assign bus.bp_target    = state_q == UPDATE ? head.target : '0;
  assign bus.bp_taken     = state_q == UPDATE && head.taken;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_target  = pred_target_q;
  assign bus.pred_timeout = pred_timeout_q;
endmodule
